imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction-fetch path: fills instruction memory from a byte stream; the CPU's PC and instruction decode later read that memory.
- Accepts a length-prefixed stream of bytes over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and issues one write per word.
- Holds the CPU in reset until the program is completely loaded.

Parameters:
ADDR_WIDTH, 10, instruction memory word-address width; depth = 2**ADDR_WIDTH words
BASE_ADDR, 0, word address of the first instruction written

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
byte_valid  input  1  byte_data is valid this cycle
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts byte this cycle
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_WIDTH  instruction memory word address
mem_wdata  output  32  instruction word
busy  output  1  load in progress
done  output  1  last load completed successfully
error  output  1  last load aborted
cpu_hold  output  1  high keeps the CPU in reset

Behaviour:
- Reset values:
  - State is IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, error=0, cpu_hold=1.
- Handshake: a byte is consumed only on a rising edge with byte_valid=1 and byte_ready=1.
- byte_ready is registered:
  - 1 in LEN_HI, LEN_LO, DATA (and CHK when enabled).
  - 0 in all other states.
- State machine:
  - IDLE: start -> LEN_HI; busy=1, cpu_hold=1, done=0, error=0, word count and byte lane cleared.
  - LEN_HI: accepted byte -> len[15:8]; next state LEN_LO.
  - LEN_LO: accepted byte -> len[7:0]. Next state is decided on the full 16-bit length:
    - len=0 -> DONE.
    - len > 2**ADDR_WIDTH -> ERR.
    - otherwise -> DATA.
- DATA:
  - Bytes fill a 32-bit shift register MSB first; the first byte lands in bits [31:24].
  - A 2-bit lane counter wraps 3->0.
  - On acceptance of lane 3: the next cycle drives mem_we=1 for exactly one cycle.
    - mem_wdata = the assembled word.
    - mem_addr = BASE_ADDR + word index, truncated to ADDR_WIDTH (wraps modulo depth).
    - Write latency is 1 cycle after the 4th byte handshake.
  - byte_ready remains 1 during the write cycle; back-to-back words at one byte per cycle are sustained.
  - After the write of word len-1 -> DONE, or -> CHK when the optional feature is enabled.
- DONE:
  - busy=0, done=1, cpu_hold=0.
  - mem_we=0.
  - start -> LEN_HI (reload; cpu_hold returns to 1 in the same cycle busy rises).
- ERR:
  - busy=0, error=1, cpu_hold=1.
  - No memory writes.
  - start -> LEN_HI.
- start in LEN_HI/LEN_LO/DATA/CHK is ignored.
- Simultaneous start and byte_valid in IDLE: start is taken; the byte is not consumed (byte_ready was 0).
- Reset asserted mid-load: next cycle all outputs return to reset values. Partially written memory is not cleaned; cpu_hold=1 prevents execution.
- Stalls: byte_valid low for any number of cycles only pauses progress; no timeout.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - State CHK follows the final data write and accepts one trailing byte.
  - The trailing byte must equal the XOR of all data bytes (header excluded).
  - Match -> DONE; mismatch -> ERR.
  - For len=0 the expected checksum is 0x00, and CHK is entered directly from LEN_LO.
- Not defined: no CHK state and no trailer byte; the loader goes to DONE after the last write, and any extra bytes are not accepted (byte_ready=0).

Test Plan:
- Reset check: reset=1 for 2 cycles -> byte_ready=0, mem_we=0, busy=0, done=0, error=0, cpu_hold=1.
- Two-word load, BASE_ADDR=0, continuous stream:
  - Stimulus: start, then 00 02 20 08 00 05 AC 09 00 00.
  - Writes: mem_we pulses once at addr 0 with 0x20080005, then once at addr 1 with 0xAC090000.
  - Each write occurs 1 cycle after the 4th byte of its word.
  - Final state: done=1, cpu_hold=0, busy=0.
- Stalled stream:
  - Stimulus: same two-word load with byte_valid dropped for 3 cycles between every byte.
  - Response: identical writes, only delayed, and no extra mem_we pulses.
- Length error: ADDR_WIDTH=4, header 00 11 (17 words) -> ERR; error=1, cpu_hold=1, no mem_we.
- Reload and zero length:
  - Header 00 00 -> done=1 with no writes.
  - A following start plus one-word load 12 34 56 78 -> write at addr 0; done=1.
- Reset mid-load, and checksum (with IMEM_LOADER_CHECKSUM_EN):
  - Reset asserted after 6 bytes -> reset values next cycle.
  - Header 00 01, bytes 01 02 03 04, trailer 04 -> DONE.
  - Same load with trailer 05 -> ERR after the write of 0x01020304.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed byte stream into big-endian 32-bit word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [32:0]           DEPTH = 33'(1) << ADDR_WIDTH;

    state_t                  state, state_nxt;
    logic [15:0]             len, len_nxt;
    logic [15:0]             word_cnt, word_cnt_nxt;
    logic [1:0]              lane, lane_nxt;
    logic [23:0]             shift, shift_nxt;
    logic                    byte_ready_nxt;
    logic                    mem_we_nxt;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
    logic [31:0]             mem_wdata_nxt;
    logic                    busy_nxt;
    logic                    done_nxt;
    logic                    error_nxt;
    logic                    cpu_hold_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]              csum, csum_nxt;
`endif

    logic                    accept;
    logic [15:0]             len_full;
    logic [31:0]             assembled;
    logic [15:0]             word_cnt_inc;
    logic                    go_start;
    logic                    go_done;
    logic                    go_err;

    assign accept       = byte_valid & byte_ready;
    assign len_full     = {len[15:8], byte_data};
    assign assembled    = {shift, byte_data};
    assign word_cnt_inc = word_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            len        <= '0;
            word_cnt   <= '0;
            lane       <= '0;
            shift      <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            len        <= len_nxt;
            word_cnt   <= word_cnt_nxt;
            lane       <= lane_nxt;
            shift      <= shift_nxt;
            byte_ready <= byte_ready_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            cpu_hold   <= cpu_hold_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= csum_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        len_nxt        = len;
        word_cnt_nxt   = word_cnt;
        lane_nxt       = lane;
        shift_nxt      = shift;
        byte_ready_nxt = byte_ready;
        mem_we_nxt     = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        busy_nxt       = busy;
        done_nxt       = done;
        error_nxt      = error;
        cpu_hold_nxt   = cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_nxt       = csum;
`endif
        go_start       = 1'b0;
        go_done        = 1'b0;
        go_err         = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    go_start = 1'b1;
                end
            end

            S_LEN_HI: begin
                if (accept) begin
                    len_nxt   = {byte_data, len[7:0]};
                    state_nxt = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (accept) begin
                    len_nxt = len_full;
                    if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_nxt = S_CHK;
`else
                        go_done = 1'b1;
`endif
                    end else if ({17'd0, len_full} > DEPTH) begin
                        go_err = 1'b1;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end

            // Dropping byte_ready after the final byte marks the last write cycle,
            // so no stray byte can slip in before the load is closed out.
            S_DATA: begin
                if (accept) begin
                    shift_nxt = assembled[23:0];
                    lane_nxt  = lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_nxt  = csum ^ byte_data;
`endif
                    if (lane == 2'd3) begin
                        mem_we_nxt    = 1'b1;
                        mem_wdata_nxt = assembled;
                        mem_addr_nxt  = BASE + ADDR_WIDTH'(word_cnt);
                        word_cnt_nxt  = word_cnt_inc;
                        if (word_cnt_inc == len) begin
                            byte_ready_nxt = 1'b0;
                        end
                    end
                end else if (!byte_ready) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt      = S_CHK;
                    byte_ready_nxt = 1'b1;
`else
                    go_done = 1'b1;
`endif
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (byte_data == csum) begin
                        go_done = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_nxt      = S_IDLE;
                byte_ready_nxt = 1'b0;
                busy_nxt       = 1'b0;
                cpu_hold_nxt   = 1'b1;
            end
        endcase

        if (go_start) begin
            state_nxt      = S_LEN_HI;
            byte_ready_nxt = 1'b1;
            busy_nxt       = 1'b1;
            cpu_hold_nxt   = 1'b1;
            done_nxt       = 1'b0;
            error_nxt      = 1'b0;
            word_cnt_nxt   = '0;
            lane_nxt       = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_nxt       = '0;
`endif
        end

        if (go_done) begin
            state_nxt      = S_DONE;
            byte_ready_nxt = 1'b0;
            busy_nxt       = 1'b0;
            done_nxt       = 1'b1;
            cpu_hold_nxt   = 1'b0;
        end

        if (go_err) begin
            state_nxt      = S_ERR;
            byte_ready_nxt = 1'b0;
            busy_nxt       = 1'b0;
            error_nxt      = 1'b1;
            cpu_hold_nxt   = 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: directed and randomized loads checked against a stream-level model.
module tb_imem_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic          cpu_hold;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    int            wr_cyc_q[$];
    logic [7:0]    data_q[$];
    int            acc_q[$];
    logic [15:0]   cur_len;
    logic [7:0]    cur_delta;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write the DUT issues is logged with the cycle it was seen in.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pickGap(input int fixgap, input int rndgap);
        return fixgap + ((rndgap > 0) ? int'($urandom_range(0, rndgap)) : 0);
    endfunction

    task automatic pulseStart(input bit collide);
        start = 1'b1;
        if (collide) begin
            byte_valid = 1'b1;
            byte_data  = 8'hFF;
        end
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int tries;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        tries = 0;
        while (byte_ready !== 1'b1 && tries < 40) begin
            @(negedge clk);
            tries++;
        end
        checkOutput("byte_ready_for_byte", byte_ready, 1'b1);
        acc_q.push_back(cyc);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_byte_ready"}, byte_ready, 1'b0);
        checkOutput({name, "_mem_we"}, mem_we, 1'b0);
        checkOutput({name, "_mem_addr"}, mem_addr, 0);
        checkOutput({name, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({name, "_busy"}, busy, 1'b0);
        checkOutput({name, "_done"}, done, 1'b0);
        checkOutput({name, "_error"}, error, 1'b0);
        checkOutput({name, "_cpu_hold"}, cpu_hold, 1'b1);
    endtask

    // Sends one complete load; data_q must already hold 4*len data bytes.
    task automatic applyStimulus(input logic [15:0] len, input logic [7:0] delta, input int fixgap,
                                 input int rndgap, input int start_at, input bit collide);
        logic [7:0] csum;
        cur_len   = len;
        cur_delta = delta;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        acc_q.delete();
        pulseStart(collide);
        checkOutput("busy_on_start", busy, 1'b1);
        checkOutput("hold_on_start", cpu_hold, 1'b1);
        checkOutput("done_cleared", done, 1'b0);
        checkOutput("error_cleared", error, 1'b0);
        sendByte(len[15:8], pickGap(fixgap, rndgap));
        sendByte(len[7:0], pickGap(fixgap, rndgap));
        if (int'(len) <= DEPTH) begin
            csum = 8'h00;
            for (int i = 0; i < data_q.size(); i++) begin
                if (i == start_at) pulseStart(1'b0);
                csum ^= data_q[i];
                sendByte(data_q[i], pickGap(fixgap, rndgap));
            end
            if (CHK_EN) sendByte(csum ^ delta, pickGap(fixgap, rndgap));
        end
    endtask

    task automatic verifyLoad(input string name);
        int          tries;
        bit          len_ok;
        bit          exp_ok;
        int          n_exp;
        logic [31:0] word;
        tries = 0;
        while (done !== 1'b1 && error !== 1'b1 && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        checkOutput({name, "_finished_in_time"}, tries < 200, 1'b1);
        repeat (3) @(negedge clk);
        len_ok = (int'(cur_len) <= DEPTH);
        exp_ok = len_ok && (!CHK_EN || cur_delta == 8'h00);
        n_exp  = len_ok ? int'(cur_len) : 0;
        checkOutput({name, "_write_count"}, wr_addr_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < wr_addr_q.size(); i++) begin
            word = {data_q[4*i], data_q[4*i+1], data_q[4*i+2], data_q[4*i+3]};
            checkOutput($sformatf("%s_wr%0d_addr", name, i), wr_addr_q[i], i % DEPTH);
            checkOutput($sformatf("%s_wr%0d_data", name, i), wr_data_q[i], word);
            checkOutput($sformatf("%s_wr%0d_latency", name, i), wr_cyc_q[i], acc_q[2 + 4*i + 3] + 1);
        end
        checkOutput({name, "_done"}, done, exp_ok);
        checkOutput({name, "_error"}, error, !exp_ok);
        checkOutput({name, "_busy"}, busy, 1'b0);
        checkOutput({name, "_cpu_hold"}, cpu_hold, !exp_ok);
        checkOutput({name, "_byte_ready_idle"}, byte_ready, 1'b0);
    endtask

    initial begin
        logic [15:0] rlen;
        logic [7:0]  rdelta;

        $display("[TB] imem_loader bench, ADDR_WIDTH=%0d, checksum=%0d", AW, CHK_EN);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clk);

        // Two-word load, continuous, with a byte presented alongside start in IDLE.
        data_q = {8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
        applyStimulus(16'd2, 8'h00, 0, 0, -1, 1'b1);
        verifyLoad("two_word");

        // Same load stalled 3 cycles between bytes, with an ignored start mid-data.
        applyStimulus(16'd2, 8'h00, 3, 0, 5, 1'b0);
        verifyLoad("stalled");

        data_q.delete();
        applyStimulus(16'h0011, 8'h00, 0, 0, -1, 1'b0);
        verifyLoad("len_17_error");

        applyStimulus(16'hFFFF, 8'h00, 0, 1, -1, 1'b0);
        verifyLoad("len_ffff_error");

        for (int i = 0; i < 4 * DEPTH; i++) data_q.push_back(8'($urandom));
        applyStimulus(16'(DEPTH), 8'h00, 0, 2, -1, 1'b0);
        verifyLoad("len_full_depth");

        data_q.delete();
        applyStimulus(16'd0, 8'h00, 0, 0, -1, 1'b0);
        verifyLoad("zero_len");

        data_q = {8'h12, 8'h34, 8'h56, 8'h78};
        applyStimulus(16'd1, 8'h00, 0, 0, -1, 1'b0);
        verifyLoad("one_word");

        // Reset after six bytes; the first word has just been written.
        data_q = {8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pulseStart(1'b0);
        sendByte(8'h00, 0);
        sendByte(8'h02, 0);
        for (int i = 0; i < 4; i++) sendByte(data_q[i], 0);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("midload_reset");
        checkOutput("midload_first_write_seen", wr_data_q.size(), 1);
        reset = 1'b0;
        @(negedge clk);

        data_q = {8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus(16'd1, 8'h00, 0, 0, -1, 1'b0);
        verifyLoad("chk_good");
        applyStimulus(16'd1, 8'h01, 0, 0, -1, 1'b0);
        verifyLoad("chk_bad");

        for (int k = 0; k < 4; k++) begin
            rlen   = 16'($urandom_range(1, 6));
            rdelta = ($urandom_range(0, 2) == 0) ? 8'h5A : 8'h00;
            data_q.delete();
            for (int i = 0; i < 4 * int'(rlen); i++) data_q.push_back(8'($urandom));
            applyStimulus(rlen, rdelta, 0, 2, -1, 1'b0);
            verifyLoad($sformatf("random%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
